// File: rtl/byte_accumulator.sv
// Running-sum accumulator: adds an unsigned DATA_W-bit sample into a SUM_W-bit
// registered total on every valid cycle. Define ACC_SATURATE_EN to clamp at all-ones instead of wrapping.
module byte_accumulator #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [SUM_W-1:0]  sum,
    output logic              carry
);

    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] sum_next;
    logic             carry_reg;
    logic             carry_next;
    logic [SUM_W:0]   add_full;

    // One extra bit holds the carry-out of the addition.
    assign add_full = {1'b0, sum_reg} + {{(SUM_W + 1 - DATA_W){1'b0}}, data_in};

    always_comb begin
        sum_next   = sum_reg;
        carry_next = carry_reg;
        if (clr) begin
            sum_next   = '0;
            carry_next = 1'b0;
        end else if (data_valid) begin
`ifdef ACC_SATURATE_EN
            if (add_full[SUM_W]) begin
                sum_next   = '1;
                carry_next = 1'b1;
            end else begin
                sum_next   = add_full[SUM_W-1:0];
                carry_next = 1'b0;
            end
`else
            sum_next   = add_full[SUM_W-1:0];
            carry_next = add_full[SUM_W];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
        end
    end

    assign sum   = sum_reg;
    assign carry = carry_reg;

endmodule

// File: tb/tb_byte_accumulator.sv
// Directed + random bench for byte_accumulator; expected results come from a
// small reference model and are queued per stimulus step, then popped after the edge.
module tb_byte_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        clr;
    logic [15:0] sum;
    logic        carry;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_sum   = 16'h0000;
    logic        m_carry = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    int          step_no  = 0;

    byte_accumulator #(.DATA_W(8), .SUM_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_valid(data_valid),
        .data_in   (data_in),
        .clr       (clr),
        .sum       (sum),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    // Reference model of one rising edge.
    task automatic model_edge(input logic r, input logic c, input logic v, input logic [7:0] d);
        logic [16:0] t;
        t = {1'b0, m_sum} + {9'd0, d};
        if (r || c) begin
            m_sum   = 16'h0000;
            m_carry = 1'b0;
        end else if (v) begin
`ifdef ACC_SATURATE_EN
            m_sum   = t[16] ? 16'hFFFF : t[15:0];
            m_carry = t[16];
`else
            m_sum   = t[15:0];
            m_carry = t[16];
`endif
        end
    endtask

    task automatic step(input string tag, input logic r, input logic c, input logic v, input logic [7:0] d);
        exp_t e;
        exp_t got;
        rst        = r;
        clr        = c;
        data_valid = v;
        data_in    = v ? d : 8'hxx;
        model_edge(r, c, v, d);
        e.sum   = m_sum;
        e.carry = m_carry;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        checks++;
        assert (sb_q.size() != 0) else begin
            failures++;
            $error("FAIL %s step=%0d scoreboard empty", tag, step_no);
        end
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            checks++;
            assert (sum === got.sum) else begin
                failures++;
                $error("FAIL %s step=%0d sum observed=%h expected=%h", tag, step_no, sum, got.sum);
            end
            checks++;
            assert (carry === got.carry) else begin
                failures++;
                $error("FAIL %s step=%0d carry observed=%b expected=%b", tag, step_no, carry, got.carry);
            end
            $display("step=%0d %s rst=%b clr=%b v=%b d=%h sum=%h carry=%b", step_no, tag, r, c, v, d, sum, carry);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; data_valid = 1'b0; data_in = 8'h00;

        // Reset
        step("reset", 1'b1, 1'b0, 1'b0, 8'h00);
        step("reset_rel", 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        assert (sum === 16'h0000 && carry === 1'b0) else begin
            failures++;
            $error("FAIL reset_const observed=%h/%b expected=0000/0", sum, carry);
        end

        // Simple accumulate
        step("acc01", 1'b0, 1'b0, 1'b1, 8'h01);
        step("acc02", 1'b0, 1'b0, 1'b1, 8'h02);
        step("accFF", 1'b0, 1'b0, 1'b1, 8'hFF);
        checks++;
        assert (sum === 16'h0102 && carry === 1'b0) else begin
            failures++;
            $error("FAIL acc_const observed=%h/%b expected=0102/0", sum, carry);
        end

        // Wrap: preload to FEFF, then FF -> FFFE, 02 -> wrap, 01 -> no carry
        step("clr", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) step("preload", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("preloadFE", 1'b0, 1'b0, 1'b1, 8'hFE);
        checks++;
        assert (sum === 16'hFEFF) else begin
            failures++;
            $error("FAIL preload observed=%h expected=FEFF", sum);
        end
        step("to_FFFE", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("wrap", 1'b0, 1'b0, 1'b1, 8'h02);
        step("after_wrap", 1'b0, 1'b0, 1'b1, 8'h01);

        // Saturation boundary: FFFE + 05, then + 00
        step("clr", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 257; i++) step("preload", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("sub1", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) step("preload", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("toFFFE", 1'b0, 1'b0, 1'b1, 8'hFE);
        step("add05", 1'b0, 1'b0, 1'b1, 8'h05);
        step("add00", 1'b0, 1'b0, 1'b1, 8'h00);
        step("add00b", 1'b0, 1'b0, 1'b1, 8'h00);

        // Random stream
        step("clr", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 500; i++) step("rand", 1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));

        // Gaps and clear
        step("clr", 1'b0, 1'b1, 1'b0, 8'h00);
        step("gap10", 1'b0, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        assert (sum === 16'h0010) else begin
            failures++;
            $error("FAIL hold observed=%h expected=0010", sum);
        end
        step("clr_over_valid", 1'b0, 1'b1, 1'b1, 8'h55);

        // Mid-stream reset at 1234
        for (int i = 0; i < 18; i++) step("to1234", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("to1234", 1'b0, 1'b0, 1'b1, 8'h46);
        checks++;
        assert (sum === 16'h1234) else begin
            failures++;
            $error("FAIL pre_rst observed=%h expected=1234", sum);
        end
        step("rst_mid", 1'b1, 1'b0, 1'b1, 8'h77);
        step("post_rst", 1'b0, 1'b0, 1'b1, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
